dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the data-memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data-memory word width.
REQ-003 The block SHALL have port clka, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports p0_req_valid / p1_req_valid, input, 1 bit each: requester 0 (pipeline MEM stage) / requester 1 (loader/debug) presents a request.
REQ-006 The block SHALL have ports p0_req_ready / p1_req_ready, output, 1 bit each: the request is accepted this cycle.
REQ-007 The block SHALL have ports pN_req_we (input, 1), pN_req_addr (input, ADDR_W) and pN_req_wdata (input, DATA_W) for N=0,1: write enable, word address and write data.
REQ-008 The block SHALL have ports pN_rsp_valid (output, 1) and pN_rsp_rdata (output, DATA_W) for N=0,1: read-response strobe and read data.
REQ-009 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_din (output, DATA_W): drive the single-port data memory (ena/wea/addra/dina).
REQ-010 The block SHALL have port mem_dout, input, DATA_W: memory read data, valid one cycle after an enabled read.

Function
REQ-011 The block SHALL define fire_N = pN_req_valid & pN_req_ready, and SHALL assert at most one pN_req_ready per cycle.
REQ-012 pN_req_ready SHALL be combinational from the valids and the arbitration state; with one valid requester, that requester SHALL be granted in the same cycle.
REQ-013 With both requesters valid, the requester not granted on the most recent fire SHALL be granted (round-robin); the last-grant register SHALL update only on a fire.
REQ-014 When no requester is valid, both readies SHALL be 0 and mem_en SHALL be 0.
REQ-015 mem_en SHALL equal fire_0 | fire_1; mem_we, mem_addr and mem_din SHALL be taken combinationally from the granted requester, with mem_we = 0 when mem_en = 0.
REQ-016 A read fire (req_we = 0) in cycle N SHALL produce pN_rsp_valid = 1 for exactly cycle N+1, with pN_rsp_rdata = mem_dout in that cycle.
REQ-017 pN_rsp_rdata SHALL be 0 whenever pN_rsp_valid = 0.
REQ-018 A write fire SHALL produce no response.
REQ-019 The block SHALL sustain one access per cycle, with back-to-back reads from either or alternating ports.
REQ-020 A write followed by a read of the same address in the next cycle SHALL return the newly written data (write-first memory ordering).
REQ-021 A requester SHALL hold valid, we, addr and wdata stable until ready; the block need not tolerate withdrawal.

Reset
REQ-022 While rst_n = 0: both rsp_valid = 0, both rsp_rdata = 0, and the last-grant register = 1, so port 0 wins the first contention.
REQ-023 Because readies and mem_* are combinational, while rst_n = 0 both readies and mem_en SHALL additionally be forced to 0.
REQ-024 A reset asserted while a read response is pending SHALL discard the response; no rsp_valid SHALL appear after reset release.

Structure
REQ-025 Package dm_arb_pkg SHALL hold ADDR_W/DATA_W defaults, NUM_REQ = 2, and the port-index type.
REQ-026 Round-robin grant logic SHALL be a sub-module rr_arb2 (valid[1:0], fire, last-grant state -> grant[1:0]); the response-tag pipeline SHALL stay in dm_arbiter.

Verification
REQ-027 After reset, p0 and p1 both read (addr 5 and 9) -> cycle 0 grants p0 (mem_addr 5), cycle 1 grants p1 (mem_addr 9); p0_rsp_valid in cycle 1 and p1_rsp_valid in cycle 2, with memory contents.
REQ-028 p0 writes 0xDEADBEEF to addr 3, then reads addr 3 the next cycle -> p0_rsp_valid one cycle later with rdata 0xDEADBEEF; no response for the write.
REQ-029 Both ports hold valid for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1; mem_en = 1 every cycle.
REQ-030 Only p1 valid, reading addr 127 -> granted the same cycle; p1_rsp_valid the next cycle; p0_rsp_valid stays 0.
REQ-031 Assert rst_n = 0 in the cycle after a p0 read fire -> no p0_rsp_valid pulse; after release, the first contention is won by p0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default widths,
// requester count and the port-index type used by the round-robin state.
package dm_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REQ    = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_t;

  // One-hot grant vector corresponding to a port index.
  function automatic logic [NUM_REQ-1:0] port_onehot(input port_idx_t idx);
    return (idx == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins at once, and under
// contention the port that lost the most recent fire is granted.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic               clka,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_fire,
  output logic [NUM_REQ-1:0] o_grant
);

  port_idx_t          r_last;
  logic [NUM_REQ-1:0] w_grant;

  // Grant is forced off during reset because it drives the memory directly.
  always_comb begin
    w_grant = '0;
    if (rst_n) begin
      case (i_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = (r_last == PORT1) ? port_onehot(PORT0) : port_onehot(PORT1);
        default: w_grant = '0;
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT1;
    end else if (i_fire) begin
      r_last <= w_grant[1] ? PORT1 : PORT0;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage (p0) and
// the loader/debug port (p1); read data returns one cycle after the fire.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_we;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_fire;
  logic [NUM_REQ-1:0] r_rsp_pend;
  logic [DATA_W-1:0]  w_rsp_rdata [NUM_REQ];

  assign w_valid = {p1_req_valid, p0_req_valid};
  assign w_we    = {p1_req_we, p0_req_we};

  rr_arb2 u_rr_arb2 (
    .clka    (clka),
    .rst_n   (rst_n),
    .i_valid (w_valid),
    .i_fire  (|w_fire),
    .o_grant (w_grant)
  );

  assign w_fire       = w_valid & w_grant;
  assign p0_req_ready = w_grant[0];
  assign p1_req_ready = w_grant[1];

  assign mem_en   = |w_fire;
  assign mem_we   = mem_en & (w_grant[1] ? p1_req_we : p0_req_we);
  assign mem_addr = w_grant[1] ? p1_req_addr  : p0_req_addr;
  assign mem_din  = w_grant[1] ? p1_req_wdata : p0_req_wdata;

  // Response tag: one bit per port marking a read issued last cycle.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_pend <= '0;
    end else begin
      r_rsp_pend <= w_fire & ~w_we;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign w_rsp_rdata[gi] = r_rsp_pend[gi] ? mem_dout : '0;
  end

  assign p0_rsp_valid = r_rsp_pend[0];
  assign p1_rsp_valid = r_rsp_pend[1];
  assign p0_rsp_rdata = w_rsp_rdata[0];
  assign p1_rsp_rdata = w_rsp_rdata[1];

endmodule
